// File: rtl/md_ctrl.sv
// HI/LO multiply-divide sequencer: latches an operation, waits LATENCY cycles, captures HI/LO.
// Optional build macro MD_DIVZERO_TRAP_EN: divide-by-zero sets div_zero and leaves HI/LO untouched.
module md_ctrl #(
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op_div,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        md_set_md,
    output logic [31:0] md_data_a,
    output logic [31:0] md_data_b,
    input  logic [31:0] md_out_high,
    input  logic [31:0] md_out_low,
    input  logic        md_zero
);

    localparam logic [3:0] LAT_CNT = 4'(LATENCY);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        op_div_q, op_div_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        capture;

`ifdef MD_DIVZERO_TRAP_EN
    logic        div_zero_q, div_zero_d;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_div_d = op_div_q;
        a_d      = a_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        capture  = 1'b0;
`ifdef MD_DIVZERO_TRAP_EN
        div_zero_d = div_zero_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_ISSUE;
                    op_div_d = op_div;
                    a_d      = src_a;
                    b_d      = src_b;
`ifdef MD_DIVZERO_TRAP_EN
                    div_zero_d = 1'b0;
`endif
                end else begin
                    // Direct writes only land when no operation is being accepted.
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                cnt_d   = LAT_CNT;
            end
            S_WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d = S_DONE;
                    cnt_d   = 4'd0;
                    capture = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (capture) begin
            if (!op_div_q) begin
                hi_d = md_out_high;
                lo_d = md_out_low;
            end else if (!md_zero) begin
                // Divider reports quotient on high, remainder on low; HI holds remainder.
                hi_d = md_out_low;
                lo_d = md_out_high;
            end else begin
`ifdef MD_DIVZERO_TRAP_EN
                div_zero_d = 1'b1;
`else
                hi_d = a_q;
                lo_d = 32'hFFFF_FFFF;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            op_div_q <= 1'b0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_div_q <= op_div_d;
            a_q      <= a_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

`ifdef MD_DIVZERO_TRAP_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_zero_q <= 1'b0;
        end else begin
            div_zero_q <= div_zero_d;
        end
    end

    assign div_zero = div_zero_q;
`else
    assign div_zero = 1'b0;
`endif

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign md_set_md = op_div_q;
    assign md_data_a = a_q;
    assign md_data_b = b_q;

endmodule

// File: doc/md_ctrl.md
MD_CTRL -- requirements
Module: md_ctrl

Interface
REQ-001 SHALL have parameter LATENCY, default 1, meaning cycles from multiplier/divider input sample to result valid (legal range 1..15).
REQ-002 SHALL have port clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  in  1  operation request, sampled only in IDLE.
REQ-005 SHALL have port op_div  in  1  1 = signed divide, 0 = multiply; sampled with start.
REQ-006 SHALL have ports src_a, src_b  in  32  operands; sampled with start.
REQ-007 SHALL have ports hi_we, lo_we  in  1  direct HI/LO write strobes (mthi/mtlo); wdata  in  32  write data.
REQ-008 SHALL have ports busy  out  1; done  out  1  one-cycle completion pulse; div_zero  out  1  divide-by-zero flag.
REQ-009 SHALL have ports hi, lo  out  32  architectural HI/LO registers.
REQ-010 SHALL have ports md_set_md  out  1; md_data_a, md_data_b  out  32; md_out_high, md_out_low  in  32; md_zero  in  1; these connect to the multiply/divide unit.

Function
REQ-011 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE; busy = (state != IDLE).
REQ-012 SHALL, in IDLE with start=1 at edge E0, latch op_div/src_a/src_b and enter ISSUE; start while busy SHALL be ignored with no state change.
REQ-013 SHALL drive md_set_md, md_data_a and md_data_b continuously from the latched op and operands.
REQ-014 SHALL move ISSUE->WAIT after one cycle (edge E1), loading a 4-bit counter with LATENCY.
REQ-015 SHALL decrement the counter each WAIT cycle and enter DONE at the edge where the counter equals 1 (edge E1+LATENCY), capturing results at that same edge.
REQ-016 SHALL, on multiply capture, write HI = md_out_high and LO = md_out_low (unsigned 64-bit product).
REQ-017 SHALL, on divide capture with md_zero=0, write HI = md_out_low (remainder) and LO = md_out_high (quotient).
REQ-018 SHALL assert done for exactly the DONE cycle, with hi/lo already holding the new values, then return to IDLE.
REQ-019 SHALL clear div_zero when a new start is accepted; otherwise div_zero holds its value.
REQ-020 SHALL apply hi_we/lo_we only in IDLE with start=0; strobes while busy, or coincident with an accepted start, SHALL be dropped.
REQ-021 SHALL allow hi_we and lo_we in the same cycle, writing wdata to both registers.

Reset
REQ-022 SHALL, on reset low at any time including mid-operation, enter IDLE immediately and clear hi, lo, done, div_zero, the counter, the latched op (so md_set_md=0) and the latched operands (so md_data_a = md_data_b = 0).
REQ-023 SHALL NOT complete or capture the aborted operation after reset releases.

Configuration
REQ-024 SHALL support macro MD_DIVZERO_TRAP_EN.
REQ-025 SHALL, with MD_DIVZERO_TRAP_EN defined, on divide capture with md_zero=1, leave hi/lo unchanged, set div_zero=1 and still pulse done.
REQ-026 SHALL, without MD_DIVZERO_TRAP_EN, tie div_zero to 0 and, on divide capture with md_zero=1, write HI = latched src_a and LO = 32'hFFFFFFFF, pulsing done.

Verification
REQ-027 SHALL cover multiply: start, op_div=0, src_a=7, src_b=32'hFFFFFFFD -> done at edge E1+LATENCY, HI=32'h00000006, LO=32'hFFFFFFEB.
REQ-028 SHALL cover signed divide: src_a=32'hFFFFFFF9 (-7), src_b=2 -> HI=32'hFFFFFFFF, LO=32'hFFFFFFFD.
REQ-029 SHALL cover divide by zero: HI=LO=32'h12345678 preloaded via hi_we/lo_we, then src_a=5, src_b=0 -> with macro: div_zero=1 and HI/LO unchanged; without macro: HI=5, LO=32'hFFFFFFFF, div_zero=0.
REQ-030 SHALL cover start pulsed during WAIT with different operands -> ignored; the original result is written and done pulses exactly once.
REQ-031 SHALL cover reset asserted in WAIT -> hi=lo=0, busy=0 and done=0 immediately; no done pulse follows release.
REQ-032 SHALL cover hi_we=1 coincident with start in IDLE, wdata=32'hDEADBEEF -> write dropped; HI equals the operation result.
